// File: rtl/cache_controller_param_if.sv
// CPU/array/memory bundle for cache_controller_param; slave = controller, master = cache array + CPU + memory side.
// Widths follow the controller's TAG_W/INDEX_W/BLOCK_W/COUNT_W parameters.
interface cache_controller_param_if #(
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 3,
    parameter int BLOCK_W = 32,
    parameter int COUNT_W = 16
);
    localparam int ADDR_W = TAG_W + INDEX_W;

    logic               read;
    logic               write;
    logic               hit;
    logic               dirty;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   victim_tag;
    logic [BLOCK_W-1:0] victim_data;
    logic               busywait;
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    logic               fill_en;
    logic [TAG_W-1:0]   fill_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [BLOCK_W-1:0] fill_data;
    logic               clear_counters;
    logic [COUNT_W-1:0] hit_count;
    logic [COUNT_W-1:0] miss_count;
    logic [COUNT_W-1:0] wb_count;

    modport slave (
        input  read, write, hit, dirty, req_tag, req_index, victim_tag, victim_data,
        input  mem_readdata, mem_busywait, clear_counters,
        output busywait, mem_read, mem_write, mem_address, mem_writedata,
        output fill_en, fill_tag, fill_index, fill_data, hit_count, miss_count, wb_count
    );

    modport master (
        output read, write, hit, dirty, req_tag, req_index, victim_tag, victim_data,
        output mem_readdata, mem_busywait, clear_counters,
        input  busywait, mem_read, mem_write, mem_address, mem_writedata,
        input  fill_en, fill_tag, fill_index, fill_data, hit_count, miss_count, wb_count
    );
endinterface

// File: rtl/cache_controller_param.sv
// Write-back/write-allocate cache controller: miss costs WRITE_BACK(>=2, dirty only) + MEM_READ(>=2) + FILL(1) cycles.
// Stalls the CPU via busywait (combinational on a miss in IDLE); waits on mem_busywait busy-then-free handshakes.
module cache_controller_param #(
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 3,
    parameter int BLOCK_W = 32,
    parameter int COUNT_W = 16
) (
    input logic                    clock,
    input logic                    reset,
    cache_controller_param_if.slave bus
);
    localparam int ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_READ   = 2'd2,
        FILL       = 2'd3
    } state_t;

    state_t state, state_next;

    logic [TAG_W-1:0]   req_tag_r;
    logic [INDEX_W-1:0] req_index_r;
    logic [TAG_W-1:0]   victim_tag_r;
    logic [BLOCK_W-1:0] victim_data_r;
    logic               seen_busy;
    logic               refill_pending;
    logic [BLOCK_W-1:0] fill_data_r;
    logic [TAG_W-1:0]   fill_tag_r;
    logic [INDEX_W-1:0] fill_index_r;
    logic [COUNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

    logic               access, miss, done, mem_phase;
    logic               busywait_c, mem_read_c, mem_write_c, fill_en_c;
    logic [ADDR_W-1:0]  mem_address_c;
    logic [BLOCK_W-1:0] mem_writedata_c;
    logic               hit_inc, miss_inc, wb_inc;

    assign access    = bus.read | bus.write;
    assign miss      = access & ~bus.hit;
    // Completion needs a busy period first, so a stale free cycle at entry is ignored.
    assign done      = seen_busy & ~bus.mem_busywait;
    assign mem_phase = (state == WRITE_BACK) || (state == MEM_READ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        busywait_c      = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        mem_address_c   = '0;
        mem_writedata_c = '0;
        fill_en_c       = 1'b0;
        case (state)
            IDLE: begin
                busywait_c = miss;
                if (miss) state_next = bus.dirty ? WRITE_BACK : MEM_READ;
            end
            WRITE_BACK: begin
                busywait_c      = 1'b1;
                mem_write_c     = 1'b1;
                mem_address_c   = {victim_tag_r, req_index_r};
                mem_writedata_c = victim_data_r;
                if (done) state_next = MEM_READ;
            end
            MEM_READ: begin
                busywait_c    = 1'b1;
                mem_read_c    = 1'b1;
                mem_address_c = {req_tag_r, req_index_r};
                if (done) state_next = FILL;
            end
            FILL: begin
                busywait_c = 1'b1;
                fill_en_c  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_tag_r      <= '0;
            req_index_r    <= '0;
            victim_tag_r   <= '0;
            victim_data_r  <= '0;
            seen_busy      <= 1'b0;
            refill_pending <= 1'b0;
            fill_data_r    <= '0;
            fill_tag_r     <= '0;
            fill_index_r   <= '0;
        end else begin
            if (state == IDLE && miss) begin
                req_tag_r     <= bus.req_tag;
                req_index_r   <= bus.req_index;
                victim_tag_r  <= bus.victim_tag;
                victim_data_r <= bus.victim_data;
            end
            if (mem_phase && state_next == state) seen_busy <= seen_busy | bus.mem_busywait;
            else                                  seen_busy <= 1'b0;
            if (state == MEM_READ && done) begin
                fill_data_r  <= bus.mem_readdata;
                fill_tag_r   <= req_tag_r;
                fill_index_r <= req_index_r;
            end
            if (state == FILL)                         refill_pending <= 1'b1;
            else if (state == IDLE && access && bus.hit) refill_pending <= 1'b0;
        end
    end

    assign hit_inc  = (state == IDLE) && access && bus.hit && !refill_pending;
    assign miss_inc = (state == IDLE) && miss;
    assign wb_inc   = (state == WRITE_BACK) && done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (bus.clear_counters) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_inc  && hit_cnt  != {COUNT_W{1'b1}}) hit_cnt  <= hit_cnt  + COUNT_W'(1);
            if (miss_inc && miss_cnt != {COUNT_W{1'b1}}) miss_cnt <= miss_cnt + COUNT_W'(1);
            if (wb_inc   && wb_cnt   != {COUNT_W{1'b1}}) wb_cnt   <= wb_cnt   + COUNT_W'(1);
        end
    end

    // The IDLE stall is combinational on CPU inputs, so reset must mask it directly.
    assign bus.busywait      = busywait_c & ~reset;
    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.mem_address   = mem_address_c;
    assign bus.mem_writedata = mem_writedata_c;
    assign bus.fill_en       = fill_en_c;
    assign bus.fill_tag      = fill_tag_r;
    assign bus.fill_index    = fill_index_r;
    assign bus.fill_data     = fill_data_r;
    assign bus.hit_count     = hit_cnt;
    assign bus.miss_count    = miss_cnt;
    assign bus.wb_count      = wb_cnt;
endmodule

// File: tb/tb_cache_controller_param.sv
// Bench for cache_controller_param: scoreboarded memory/fill transactions plus per-scenario counter checks.
module tb_cache_controller_param;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cache_controller_param_if #(.TAG_W(3), .INDEX_W(3), .BLOCK_W(32), .COUNT_W(16)) bus ();
    cache_controller_param_if #(.TAG_W(3), .INDEX_W(3), .BLOCK_W(32), .COUNT_W(2))  bus2 ();

    cache_controller_param #(.TAG_W(3), .INDEX_W(3), .BLOCK_W(32), .COUNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .bus(bus));
    cache_controller_param #(.TAG_W(3), .INDEX_W(3), .BLOCK_W(32), .COUNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .bus(bus2));

    int tests = 0;
    int fails = 0;

    logic [5:0]  rd_q[$];
    logic [37:0] wb_q[$];
    logic [37:0] fill_q[$];

    // Memory model: busy for mem_lat cycles after mem_zf free cycles of each strobe phase.
    int          mem_zf = 0;
    int          mem_lat = 2;
    logic [31:0] mem_rdata = '0;
    int          mk = 0;
    int          mlast = 0;
    int          kind;
    always @(negedge clock) begin
        kind = bus.mem_write ? 2 : (bus.mem_read ? 1 : 0);
        if (kind == 0 || kind != mlast) mk = 0;
        else mk++;
        mlast = kind;
        bus.mem_busywait = (kind != 0) && (mk >= mem_zf) && (mk < mem_zf + mem_lat);
        bus.mem_readdata = mem_rdata;
    end

    // Scoreboard monitor: pops expected transactions as the DUT issues them.
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [5:0]  ea;
    logic [37:0] eb;
    always @(negedge clock) begin
        if (reset) begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (bus.mem_read && !prev_rd) begin
                tests++;
                if (rd_q.size() == 0) begin
                    fails++; $display("FAIL rd_txn: unexpected read addr=%b", bus.mem_address);
                end else begin
                    ea = rd_q.pop_front();
                    if (bus.mem_address !== ea) begin
                        fails++; $display("FAIL rd_txn: addr=%b expected %b", bus.mem_address, ea);
                    end
                end
            end
            if (bus.mem_write && !prev_wr) begin
                tests++;
                if (wb_q.size() == 0) begin
                    fails++; $display("FAIL wb_txn: unexpected write addr=%b", bus.mem_address);
                end else begin
                    eb = wb_q.pop_front();
                    if ({bus.mem_address, bus.mem_writedata} !== eb) begin
                        fails++;
                        $display("FAIL wb_txn: got %h expected %h", {bus.mem_address, bus.mem_writedata}, eb);
                    end
                end
            end
            if (bus.fill_en) begin
                tests++;
                if (fill_q.size() == 0) begin
                    fails++; $display("FAIL fill_txn: unexpected fill");
                end else begin
                    eb = fill_q.pop_front();
                    if ({bus.fill_tag, bus.fill_index, bus.fill_data} !== eb) begin
                        fails++;
                        $display("FAIL fill_txn: got %h expected %h",
                                 {bus.fill_tag, bus.fill_index, bus.fill_data}, eb);
                    end
                end
            end
            prev_rd = bus.mem_read;
            prev_wr = bus.mem_write;
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_cnt();
        bus.clear_counters = 1'b1;
        tick();
        bus.clear_counters = 1'b0;
    endtask

    task automatic do_miss(input logic wr, input logic [2:0] tag, input logic [2:0] idx, input logic d,
                           input logic [2:0] vtag, input logic [31:0] vdata, input logic [31:0] rdata,
                           input int zf, input int lat);
        int rd_cyc, wr_cyc, bad;
        bit seen;
        mem_zf = zf; mem_lat = lat; mem_rdata = rdata;
        rd_q.push_back({tag, idx});
        if (d) wb_q.push_back({vtag, idx, vdata});
        fill_q.push_back({tag, idx, rdata});
        bus.read = !wr; bus.write = wr; bus.hit = 1'b0; bus.dirty = d;
        bus.req_tag = tag; bus.req_index = idx; bus.victim_tag = vtag; bus.victim_data = vdata;
        #1;
        tests++;
        if (bus.busywait !== 1'b1) begin
            fails++; $display("FAIL miss_stall: busywait=%b expected 1", bus.busywait);
        end
        tick();
        // Scramble CPU-side inputs: the controller must work from its captured copies.
        bus.req_tag = ~tag; bus.req_index = ~idx; bus.victim_tag = ~vtag; bus.victim_data = ~vdata;
        bus.dirty = ~d;
        rd_cyc = 0; wr_cyc = 0; bad = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.fill_en) seen = 1;
            else begin
                if (bus.mem_read) begin
                    rd_cyc++;
                    if (bus.mem_address !== {tag, idx}) bad++;
                end
                if (bus.mem_write) wr_cyc++;
                if (bus.busywait !== 1'b1) bad++;
                tick();
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL fill_seen: no fill_en within 60 cycles"); end
        tests++;
        if (rd_cyc != zf + lat + 1) begin
            fails++; $display("FAIL rd_cycles: got %0d expected %0d", rd_cyc, zf + lat + 1);
        end
        tests++;
        if (wr_cyc != (d ? zf + lat + 1 : 0)) begin
            fails++; $display("FAIL wb_cycles: got %0d expected %0d", wr_cyc, d ? zf + lat + 1 : 0);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL miss_phase: %0d bad cycles expected 0", bad); end
        bus.req_tag = tag; bus.req_index = idx; bus.victim_tag = tag; bus.hit = 1'b1; bus.dirty = 1'b0;
        tick();
        tests++;
        if ({bus.fill_en, bus.busywait} !== 2'b00) begin
            fails++; $display("FAIL after_fill: fill_en,busywait=%b expected 00", {bus.fill_en, bus.busywait});
        end
        tick();
        bus.read = 1'b0; bus.write = 1'b0; bus.hit = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.busywait, bus.mem_read, bus.mem_write, bus.fill_en} !== 4'b0000 || bus.mem_address !== 6'd0
            || bus.fill_data !== 32'd0) begin
            fails++; $display("FAIL reset_outputs: strobes=%b addr=%b fill_data=%h expected zeros",
                              {bus.busywait, bus.mem_read, bus.mem_write, bus.fill_en}, bus.mem_address, bus.fill_data);
        end
        tests++;
        if ({bus.hit_count, bus.miss_count, bus.wb_count} !== 48'd0) begin
            fails++; $display("FAIL reset_counters: %h expected 0", {bus.hit_count, bus.miss_count, bus.wb_count});
        end
    endtask

    task automatic test_read_hit();
        bus.read = 1'b1; bus.hit = 1'b1; bus.dirty = 1'b1;
        #1;
        tests++;
        if (bus.busywait !== 1'b0) begin fails++; $display("FAIL hit_stall: busywait=%b expected 0", bus.busywait); end
        tick();
        tests++;
        if ({bus.mem_read, bus.mem_write, bus.fill_en} !== 3'b000 || bus.hit_count !== 16'd1) begin
            fails++; $display("FAIL read_hit: strobes=%b hit_count=%0d expected 000/1",
                              {bus.mem_read, bus.mem_write, bus.fill_en}, bus.hit_count);
        end
        bus.read = 1'b0; bus.hit = 1'b0; bus.dirty = 1'b0;
    endtask

    task automatic test_clean_miss();
        clear_cnt();
        do_miss(1'b0, 3'b101, 3'b010, 1'b0, 3'b111, 32'h0BADF00D, 32'hDEADBEEF, 0, 3);
        tests++;
        if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0 || bus.wb_count !== 16'd0) begin
            fails++; $display("FAIL clean_counts: miss=%0d hit=%0d wb=%0d expected 1/0/0",
                              bus.miss_count, bus.hit_count, bus.wb_count);
        end
        tests++;
        if (bus.fill_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL fill_hold: %h expected deadbeef", bus.fill_data);
        end
    endtask

    task automatic test_dirty_miss();
        clear_cnt();
        do_miss(1'b1, 3'b110, 3'b001, 1'b1, 3'b011, 32'h12345678, 32'hCAFEF00D, 0, 2);
        tests++;
        if (bus.wb_count !== 16'd1 || bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
            fails++; $display("FAIL dirty_counts: wb=%0d miss=%0d hit=%0d expected 1/1/0",
                              bus.wb_count, bus.miss_count, bus.hit_count);
        end
    endtask

    task automatic test_no_early_exit();
        clear_cnt();
        do_miss(1'b0, 3'b010, 3'b111, 1'b0, 3'b000, 32'h0, 32'h55AA33CC, 1, 2);
    endtask

    task automatic test_back_to_back();
        clear_cnt();
        bus.read = 1'b1; bus.write = 1'b1; bus.hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (bus.busywait !== 1'b0) begin fails++; $display("FAIL b2b_stall: cycle %0d busywait=1", i); end
            tick();
        end
        tests++;
        if (bus.hit_count !== 16'd4 || bus.miss_count !== 16'd0) begin
            fails++; $display("FAIL b2b_counts: hit=%0d miss=%0d expected 4/0", bus.hit_count, bus.miss_count);
        end
        bus.read = 1'b0; bus.write = 1'b0; bus.hit = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_zf = 0; mem_lat = 20;
        rd_q.push_back({3'b100, 3'b011});
        bus.read = 1'b1; bus.hit = 1'b0; bus.dirty = 1'b0; bus.req_tag = 3'b100; bus.req_index = 3'b011;
        tick();
        tick();
        tests++;
        if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL mid_pre: mem_read=%b expected 1", bus.mem_read); end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({bus.mem_read, bus.busywait} !== 2'b00) begin
            fails++; $display("FAIL mid_reset: mem_read,busywait=%b expected 00", {bus.mem_read, bus.busywait});
        end
        tests++;
        if (bus.miss_count !== 16'd0) begin
            fails++; $display("FAIL mid_counters: miss=%0d expected 0", bus.miss_count);
        end
        @(negedge clock);
        reset = 1'b0;
        bus.read = 1'b0;
        tick();
        do_miss(1'b0, 3'b001, 3'b100, 1'b0, 3'b010, 32'h0, 32'hA5A5A5A5, 0, 2);
        tests++;
        if (bus.miss_count !== 16'd1) begin
            fails++; $display("FAIL mid_restart: miss=%0d expected 1", bus.miss_count);
        end
    endtask

    task automatic test_saturation();
        bus2.read = 1'b1; bus2.hit = 1'b1;
        repeat (5) tick();
        tests++;
        if (bus2.hit_count !== 2'd3) begin
            fails++; $display("FAIL sat_hit: hit_count=%0d expected 3", bus2.hit_count);
        end
        bus2.clear_counters = 1'b1;
        tick();
        tests++;
        if (bus2.hit_count !== 2'd0) begin
            fails++; $display("FAIL sat_clear: hit_count=%0d expected 0", bus2.hit_count);
        end
        bus2.clear_counters = 1'b0;
        tick();
        tests++;
        if (bus2.hit_count !== 2'd1) begin
            fails++; $display("FAIL sat_resume: hit_count=%0d expected 1", bus2.hit_count);
        end
        bus2.read = 1'b0; bus2.hit = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.read = 0; bus.write = 0; bus.hit = 0; bus.dirty = 0; bus.req_tag = 0; bus.req_index = 0;
        bus.victim_tag = 0; bus.victim_data = 0; bus.clear_counters = 0;
        bus2.read = 0; bus2.write = 0; bus2.hit = 0; bus2.dirty = 0; bus2.req_tag = 0; bus2.req_index = 0;
        bus2.victim_tag = 0; bus2.victim_data = 0; bus2.clear_counters = 0;
        bus2.mem_busywait = 0; bus2.mem_readdata = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_no_early_exit();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        tick();
        tests++;
        if (rd_q.size() + wb_q.size() + fill_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: rd=%0d wb=%0d fill=%0d left, expected 0",
                              rd_q.size(), wb_q.size(), fill_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
